// File: rtl/safety_island_pkg.sv
// Shared constants and types for the safety island memory arbiter.
package safety_island_pkg;

  localparam int unsigned NUM_PORTS_DEF       = 3;
  localparam int unsigned MAX_OUTSTANDING_DEF = 2;

  localparam int unsigned PORT_INSTR  = 0;
  localparam int unsigned PORT_DATA   = 1;
  localparam int unsigned PORT_SHADOW = 2;

  localparam int unsigned OBI_AW  = 32;
  localparam int unsigned OBI_DW  = 32;
  localparam int unsigned OBI_BEW = OBI_DW / 8;

  typedef struct packed {
    logic               we;
    logic [OBI_BEW-1:0] be;
    logic [OBI_AW-1:0]  addr;
    logic [OBI_DW-1:0]  wdata;
  } obi_req_t;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/safety_mem_arb_idq.sv
// In-order queue of granted port indices, popped as responses return.
module safety_mem_arb_idq
  import safety_island_pkg::*;
#(
  parameter int unsigned Depth = MAX_OUTSTANDING_DEF,
  parameter int unsigned Width = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = idx_width(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, rd_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (32'(cnt_q) == Depth);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
    return (32'(p) == Depth - 1) ? '0 : p + PtrW'(1);
  endfunction

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wrap_inc(wr_q);
      if (do_pop)  rd_q <= wrap_inc(rd_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CntW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CntW'(1);
    end
  end

endmodule

// File: rtl/safety_mem_arbiter.sv
// OBI N:1 memory arbiter with in-order response routing and OBI request locking.
// Define SAFETY_MEM_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module safety_mem_arbiter
  import safety_island_pkg::*;
#(
  parameter int unsigned NumPorts       = NUM_PORTS_DEF,
  parameter int unsigned MaxOutstanding = MAX_OUTSTANDING_DEF
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumPorts-1:0]              req_i,
  output logic [NumPorts-1:0]              gnt_o,
  input  logic [NumPorts-1:0]              we_i,
  input  logic [NumPorts-1:0][OBI_BEW-1:0] be_i,
  input  logic [NumPorts-1:0][OBI_AW-1:0]  addr_i,
  input  logic [NumPorts-1:0][OBI_DW-1:0]  wdata_i,
  output logic [NumPorts-1:0]              rvalid_o,
  output logic [NumPorts-1:0][OBI_DW-1:0]  rdata_o,
  output logic [NumPorts-1:0]              err_o,
  output logic                             mem_req_o,
  input  logic                             mem_gnt_i,
  output logic                             mem_we_o,
  output logic [OBI_BEW-1:0]               mem_be_o,
  output logic [OBI_AW-1:0]                mem_addr_o,
  output logic [OBI_DW-1:0]                mem_wdata_o,
  input  logic                             mem_rvalid_i,
  input  logic [OBI_DW-1:0]                mem_rdata_i,
  input  logic                             mem_err_i,
  output logic                             spurious_o
);

  localparam int unsigned IdxW = idx_width(NumPorts);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [IdxW-1:0] arb_idx, winner, head_idx, lock_idx_q;
  logic            lock_q, q_full, q_empty, handshake, rsp_pop;
  logic [CntW-1:0] out_cnt;
  obi_req_t        sel;

`ifdef SAFETY_MEM_ARB_FIXED_PRIO_EN
  // Lowest requesting index wins.
  always_comb begin
    arb_idx = '0;
    for (int unsigned i = NumPorts; i > 0; i--) begin
      if (req_i[IdxW'(i - 1)]) arb_idx = IdxW'(i - 1);
    end
  end
`else
  logic [IdxW-1:0] ptr_q;
  logic            rr_found;
  int unsigned     rr_j;

  // First requester at or after the pointer, wrapping.
  always_comb begin
    arb_idx  = ptr_q;
    rr_found = 1'b0;
    rr_j     = 0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      rr_j = (32'(ptr_q) + i) % NumPorts;
      if (!rr_found && req_i[IdxW'(rr_j)]) begin
        arb_idx  = IdxW'(rr_j);
        rr_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        ptr_q <= '0;
    else if (handshake) ptr_q <= (32'(winner) == NumPorts - 1) ? '0 : winner + IdxW'(1);
  end
`endif

  // A stalled request keeps its port until granted.
  assign winner    = lock_q ? lock_idx_q : arb_idx;
  assign mem_req_o = rst_ni & req_i[winner] & (32'(out_cnt) < MaxOutstanding);
  assign handshake = mem_req_o & mem_gnt_i;

  always_comb begin
    gnt_o         = '0;
    gnt_o[winner] = handshake;
  end

  always_comb begin
    sel.we    = we_i[winner];
    sel.be    = be_i[winner];
    sel.addr  = addr_i[winner];
    sel.wdata = wdata_i[winner];
  end

  assign mem_we_o    = sel.we;
  assign mem_be_o    = sel.be;
  assign mem_addr_o  = sel.addr;
  assign mem_wdata_o = sel.wdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q <= mem_req_o & ~mem_gnt_i & ~q_full;
      if (mem_req_o && !mem_gnt_i) lock_idx_q <= winner;
    end
  end

  safety_mem_arb_idq #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) u_idq (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (handshake),
    .data_i  (winner),
    .pop_i   (rsp_pop),
    .head_o  (head_idx),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (out_cnt)
  );

  // Responses route straight to the oldest outstanding requester.
  assign rsp_pop    = mem_rvalid_i & ~q_empty;
  assign spurious_o = rst_ni & mem_rvalid_i & q_empty;

  always_comb begin
    rvalid_o           = '0;
    err_o              = '0;
    rdata_o            = '0;
    rvalid_o[head_idx] = rsp_pop;
    err_o[head_idx]    = rsp_pop & mem_err_i;
    if (rsp_pop) rdata_o[head_idx] = mem_rdata_i;
  end

endmodule

// File: tb/tb_safety_mem_arbiter.sv
// Scoreboard bench for safety_mem_arbiter: stimulus queues expected grants/responses, a monitor checks them.
module tb_safety_mem_arbiter;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [2:0]        req_i = '0;
  logic [2:0]        gnt_o;
  logic [2:0]        we_i = 3'b010;
  logic [2:0][3:0]   be_i;
  logic [2:0][31:0]  addr_i;
  logic [2:0][31:0]  wdata_i;
  logic [2:0]        rvalid_o;
  logic [2:0][31:0]  rdata_o;
  logic [2:0]        err_o;
  logic              mem_req_o;
  logic              mem_gnt_i = 1'b0;
  logic              mem_we_o;
  logic [3:0]        mem_be_o;
  logic [31:0]       mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_rvalid_i = 1'b0;
  logic [31:0]       mem_rdata_i = '0;
  logic              mem_err_i = 1'b0;
  logic              spurious_o;

  typedef struct {
    int unsigned port;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  int unsigned exp_gnt[$];
  rsp_t        exp_rsp[$];
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned mp;
  rsp_t        mr;

  // Hand-computed grant orders.
`ifdef SAFETY_MEM_ARB_FIXED_PRIO_EN
  int unsigned seq_a[6]  = '{0, 0, 0, 0, 0, 0};
  int unsigned seq_e1[2] = '{0, 0};
  int unsigned seq_e2[2] = '{0, 0};
  int unsigned seq_f[4]  = '{0, 0, 0, 0};
`else
  int unsigned seq_a[6]  = '{0, 1, 2, 0, 1, 2};
  int unsigned seq_e1[2] = '{1, 0};
  int unsigned seq_e2[2] = '{0, 2};
  int unsigned seq_f[4]  = '{0, 1, 0, 1};
`endif

  safety_mem_arbiter #(
    .NumPorts       (3),
    .MaxOutstanding (2)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .gnt_o        (gnt_o),
    .we_i         (we_i),
    .be_i         (be_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .err_o        (err_o),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_err_i    (mem_err_i),
    .spurious_o   (spurious_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] addr_of(input int unsigned p);
    return 32'h1000_0000 + 32'(p << 8);
  endfunction

  function automatic logic [31:0] wdata_of(input int unsigned p);
    return 32'hD00D_0000 + 32'(p);
  endfunction

  function automatic logic [3:0] be_of(input int unsigned p);
    case (p)
      0:       return 4'hF;
      1:       return 4'h3;
      default: return 4'hC;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [2:0] req, input logic gnt, input logic rv,
                      input logic [31:0] rd, input logic er);
    @(posedge clk_i);
    #1;
    req_i        = req;
    mem_gnt_i    = gnt;
    mem_rvalid_i = rv;
    mem_rdata_i  = rd;
    mem_err_i    = er;
  endtask

  task automatic push_rsp(input int unsigned p, input logic [31:0] d, input logic e);
    rsp_t r;
    r.port = p;
    r.data = d;
    r.err  = e;
    exp_rsp.push_back(r);
  endtask

  // Monitor: every grant or response the DUT presents must match the queue head.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (gnt_o != '0) begin
        if (exp_gnt.size() == 0) begin
          check("gnt_unexpected", 32'(gnt_o), 32'd0);
        end else begin
          mp = exp_gnt.pop_front();
          check("gnt_vec", 32'(gnt_o), 32'(1) << mp);
          check("mem_addr", mem_addr_o, addr_of(mp));
          check("mem_wdata", mem_wdata_o, wdata_of(mp));
          check("mem_be", 32'(mem_be_o), 32'(be_of(mp)));
          check("mem_we", 32'(mem_we_o), 32'(mp == 1));
        end
      end
      if (rvalid_o != '0) begin
        if (exp_rsp.size() == 0) begin
          check("rsp_unexpected", 32'(rvalid_o), 32'd0);
        end else begin
          mr = exp_rsp.pop_front();
          check("rsp_vec", 32'(rvalid_o), 32'(1) << mr.port);
          check("rsp_data", rdata_o[2'(mr.port)], mr.data);
          check("rsp_err", 32'(err_o[2'(mr.port)]), 32'(mr.err));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int p = 0; p < 3; p++) begin
      be_i[p]    = be_of(p);
      addr_i[p]  = addr_of(p);
      wdata_i[p] = wdata_of(p);
    end

    // Reset: outputs held low even with live inputs.
    req_i = 3'b111; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    #12;
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_spurious", 32'(spurious_o), 32'd0);
    req_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    #10 rst_ni = 1'b1;

    // All ports requesting, response one cycle after each grant.
    for (int c = 0; c < 7; c++) begin
      step((c < 6) ? 3'b111 : 3'b000, 1'b1, c > 0, 32'hA000_0000 + 32'(c), c == 5);
      if (c < 6) exp_gnt.push_back(seq_a[c]);
      if (c > 0) push_rsp(seq_a[c-1], 32'hA000_0000 + 32'(c), c == 5);
      @(negedge clk_i);
      if (c < 6) check("a_mem_req", 32'(mem_req_o), 32'd1);
    end
    step(3'b000, 1'b0, 1'b0, '0, 1'b0);

    // Port 2 stalled by mem_gnt_i=0 keeps the bus while port 0 joins.
    step(3'b100, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk_i);
    check("b_addr_c1", mem_addr_o, addr_of(2));
    check("b_req_c1", 32'(mem_req_o), 32'd1);
    for (int c = 2; c <= 3; c++) begin
      step(3'b101, 1'b0, 1'b0, '0, 1'b0);
      @(negedge clk_i);
      check("b_addr_locked", mem_addr_o, addr_of(2));
    end
    step(3'b101, 1'b1, 1'b0, '0, 1'b0);
    exp_gnt.push_back(2);
    step(3'b001, 1'b1, 1'b0, '0, 1'b0);
    exp_gnt.push_back(0);
    step(3'b000, 1'b0, 1'b1, 32'hB000_0002, 1'b0);
    push_rsp(2, 32'hB000_0002, 1'b0);
    step(3'b000, 1'b0, 1'b1, 32'hB000_0000, 1'b1);
    push_rsp(0, 32'hB000_0000, 1'b1);
    step(3'b000, 1'b0, 1'b0, '0, 1'b0);

    // Full at two outstanding; a response frees a slot only on the next cycle.
    step(3'b010, 1'b1, 1'b0, '0, 1'b0); exp_gnt.push_back(1);
    step(3'b010, 1'b1, 1'b0, '0, 1'b0); exp_gnt.push_back(1);
    step(3'b010, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk_i);
    check("c_full_req", 32'(mem_req_o), 32'd0);
    step(3'b010, 1'b1, 1'b1, 32'hC000_0001, 1'b0);
    push_rsp(1, 32'hC000_0001, 1'b0);
    @(negedge clk_i);
    check("c_no_bypass", 32'(mem_req_o), 32'd0);
    step(3'b010, 1'b1, 1'b0, '0, 1'b0);
    exp_gnt.push_back(1);
    @(negedge clk_i);
    check("c_req_after_rsp", 32'(mem_req_o), 32'd1);
    step(3'b000, 1'b0, 1'b1, 32'hC000_0002, 1'b0); push_rsp(1, 32'hC000_0002, 1'b0);
    step(3'b000, 1'b0, 1'b1, 32'hC000_0003, 1'b0); push_rsp(1, 32'hC000_0003, 1'b0);
    step(3'b000, 1'b0, 1'b0, '0, 1'b0);

    // Responses with nothing outstanding are flagged and dropped.
    step(3'b000, 1'b0, 1'b1, 32'hDEAD_0001, 1'b0);
    @(negedge clk_i);
    check("d_spurious", 32'(spurious_o), 32'd1);
    check("d_no_rvalid", 32'(rvalid_o), 32'd0);
    step(3'b000, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk_i);
    check("d_spurious_pulse", 32'(spurious_o), 32'd0);
    step(3'b001, 1'b1, 1'b1, 32'hDEAD_0002, 1'b0);
    exp_gnt.push_back(0);
    @(negedge clk_i);
    check("d_spurious_with_gnt", 32'(spurious_o), 32'd1);
    check("d_no_rvalid2", 32'(rvalid_o), 32'd0);
    step(3'b000, 1'b0, 1'b1, 32'hD000_0004, 1'b0);
    push_rsp(0, 32'hD000_0004, 1'b0);
    @(negedge clk_i);
    check("d_real_rsp_not_spurious", 32'(spurious_o), 32'd0);

    // Reset with two outstanding discards them and clears the pointer.
    step(3'b011, 1'b1, 1'b0, '0, 1'b0); exp_gnt.push_back(seq_e1[0]);
    step(3'b011, 1'b1, 1'b0, '0, 1'b0); exp_gnt.push_back(seq_e1[1]);
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("e_rst_mem_req", 32'(mem_req_o), 32'd0);
    check("e_rst_gnt", 32'(gnt_o), 32'd0);
    mem_rvalid_i = 1'b1;
    #1;
    check("e_rst_rvalid", 32'(rvalid_o), 32'd0);
    check("e_rst_spurious", 32'(spurious_o), 32'd0);
    req_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    step(3'b000, 1'b0, 1'b1, 32'hE000_0000, 1'b0);
    @(negedge clk_i);
    check("e_post_rst_spurious", 32'(spurious_o), 32'd1);
    check("e_post_rst_rvalid", 32'(rvalid_o), 32'd0);
    step(3'b101, 1'b1, 1'b0, '0, 1'b0); exp_gnt.push_back(seq_e2[0]);
    step(3'b101, 1'b1, 1'b1, 32'hE000_0001, 1'b0);
    exp_gnt.push_back(seq_e2[1]);
    push_rsp(seq_e2[0], 32'hE000_0001, 1'b0);
    step(3'b000, 1'b0, 1'b1, 32'hE000_0002, 1'b0);
    push_rsp(seq_e2[1], 32'hE000_0002, 1'b0);
    step(3'b000, 1'b0, 1'b0, '0, 1'b0);

    // Ports 0 and 1 requesting continuously.
    for (int c = 0; c < 5; c++) begin
      step((c < 4) ? 3'b011 : 3'b000, 1'b1, c > 0, 32'hF000_0000 + 32'(c), 1'b0);
      if (c < 4) exp_gnt.push_back(seq_f[c]);
      if (c > 0) push_rsp(seq_f[c-1], 32'hF000_0000 + 32'(c), 1'b0);
    end
    step(3'b000, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk_i);

    check("gnt_queue_drained", exp_gnt.size(), 32'd0);
    check("rsp_queue_drained", exp_rsp.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/safety_mem_arbiter.md
SAFETY_MEM_ARBITER -- requirements
Module: safety_mem_arbiter

Interface
REQ-001 SHALL have parameter NumPorts, default 3, number of OBI requesters (instr, data, shadow).
REQ-002 SHALL have parameter MaxOutstanding, default 2, maximum accepted-but-unanswered transactions (power of two, >=1).
REQ-003 SHALL have ports clk_i  in  1  single clock; rst_ni  in  1  asynchronous active-low reset.
REQ-004 SHALL have req_i  in  NumPorts  per-port request; gnt_o  out  NumPorts  per-port grant.
REQ-005 SHALL have we_i  in  NumPorts  write enable; be_i  in  NumPorts x 4  byte enables.
REQ-006 SHALL have addr_i  in  NumPorts x 32  address; wdata_i  in  NumPorts x 32  write data.
REQ-007 SHALL have rvalid_o  out  NumPorts  response valid; rdata_o  out  NumPorts x 32  read data; err_o  out  NumPorts  response error.
REQ-008 SHALL have mem_req_o  out  1; mem_gnt_i  in  1; mem_we_o  out  1; mem_be_o  out  4; mem_addr_o  out  32; mem_wdata_o  out  32.
REQ-009 SHALL have mem_rvalid_i  in  1; mem_rdata_i  in  32; mem_err_i  in  1; spurious_o  out  1  response arrived with no outstanding transaction.

Function
REQ-010 SHALL assert mem_req_o when any req_i is high and outstanding count < MaxOutstanding; mem_* request fields SHALL be those of the selected port.
REQ-011 SHALL select the winner round-robin: first requesting port at or after pointer, wrapping NumPorts-1 -> 0.
REQ-012 SHALL, on handshake (mem_req_o & mem_gnt_i) by port k, assert gnt_o[k] in the same cycle (combinational) and set pointer to (k+1) mod NumPorts next cycle.
REQ-013 SHALL, when mem_req_o is high and mem_gnt_i low, lock the winner so the same port drives mem_* next cycle regardless of other requests (OBI stability).
REQ-014 SHALL keep gnt_o zero for all non-winning ports and for every port when mem_gnt_i is low.
REQ-015 SHALL push the winner index into an in-order ID queue on each handshake; outstanding count increments.
REQ-016 SHALL, on mem_rvalid_i with count > 0, pop the queue head h and drive rvalid_o[h]=1, rdata_o[h]=mem_rdata_i, err_o[h]=mem_err_i in the same cycle; other rvalid_o SHALL be 0.
REQ-017 SHALL, on simultaneous handshake and response, pop and push in the same cycle; count unchanged.
REQ-018 SHALL treat count == MaxOutstanding as full: mem_req_o low even if a response arrives that cycle (no bypass); lock SHALL not be set while full.
REQ-019 SHALL, on mem_rvalid_i with count == 0, pulse spurious_o for one cycle, drive no rvalid_o, and leave state unchanged.
REQ-020 SHALL add zero latency on request path and zero latency on response path (no registers on data).

Reset
REQ-021 SHALL on rst_ni low clear pointer to 0, lock to 0, count to 0, queue to empty, asynchronously.
REQ-022 SHALL hold mem_req_o, gnt_o, rvalid_o, spurious_o at 0 during reset; transactions in flight at reset SHALL be discarded.

Configuration
REQ-023 SHALL honour macro SAFETY_MEM_ARB_FIXED_PRIO_EN: defined -> fixed priority, lowest index wins, pointer unused; undefined -> round-robin per REQ-011/012. Lock behaviour (REQ-013) SHALL apply in both modes.

Structure
REQ-024 SHALL place defaults for NumPorts/MaxOutstanding and port-index constants (instr=0, data=1, shadow=2) in safety_island_pkg.
REQ-025 SHALL implement the ID queue as sub-module safety_mem_arb_idq (depth MaxOutstanding, width clog2(NumPorts), push/pop/full/empty/count).

Verification
REQ-026 SHALL test all three ports requesting continuously, mem_gnt_i=1, rvalid one cycle later -> grants cycle 0,1,2,0,1,2; responses routed to matching ports.
REQ-027 SHALL test port 2 requesting with mem_gnt_i=0 for 3 cycles while port 0 raises req -> mem_addr_o stays port 2 address, port 2 granted on cycle 4, then port 0.
REQ-028 SHALL test MaxOutstanding=2, two grants, no rvalid -> mem_req_o low; one rvalid -> mem_req_o high next cycle, not the same cycle.
REQ-029 SHALL test mem_rvalid_i=1 with empty queue -> spurious_o=1 one cycle, all rvalid_o=0, count stays 0.
REQ-030 SHALL test rst_ni low with 2 outstanding -> count 0, pointer 0; later response flagged spurious.
REQ-031 SHALL test SAFETY_MEM_ARB_FIXED_PRIO_EN defined, ports 0 and 1 requesting continuously -> port 0 granted every cycle, port 1 never.
